// File: rtl/pkt_in_writer_if.sv
// rtl/pkt_in_writer_if.sv - stream, data FIFO and user FIFO signal bundle for pkt_in_writer
interface pkt_in_writer_if #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int SPT_W  = 8
);
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [DATA_W/8-1:0] s_axis_tstrb;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                s_axis_tready;

    logic                fifo_full;
    logic                fifo_almost_full;
    logic                fifo_wr_en;
    logic [DATA_W-1:0]   fifo_din_data;
    logic [DATA_W/8-1:0] fifo_din_strb;
    logic                fifo_din_last;

    logic                user_full;
    logic                user_wr_en;
    logic [LEN_W-1:0]    user_len;
    logic [SPT_W-1:0]    user_spt;

    // Stream source and FIFO-flag side (the environment around the writer)
    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        output fifo_full, fifo_almost_full,
        input  fifo_wr_en, fifo_din_data, fifo_din_strb, fifo_din_last,
        output user_full,
        input  user_wr_en, user_len, user_spt
    );

    // Writer side
    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        input  fifo_full, fifo_almost_full,
        output fifo_wr_en, fifo_din_data, fifo_din_strb, fifo_din_last,
        input  user_full,
        output user_wr_en, user_len, user_spt
    );
endinterface

// File: rtl/pkt_in_writer.sv
// rtl/pkt_in_writer.sv - ingress stream to data/user FIFO writer; optional whole-packet drop via PKT_DROP_EN
module pkt_in_writer #(
    parameter int                           C_AXIS_DATA_WIDTH     = 64,
    parameter int                           C_AXIS_LEN_DATA_WIDTH = 16,
    parameter int                           C_AXIS_SPT_DATA_WIDTH = 8,
    parameter logic [C_AXIS_SPT_DATA_WIDTH-1:0] C_SRC_PORT        = '0
) (
    input  logic        asclk,
    input  logic        aresetn,
    pkt_in_writer_if.slave bus,
    output logic [31:0] pkt_cnt,
    output logic [31:0] drop_cnt
);
    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int LEN_W  = C_AXIS_LEN_DATA_WIDTH;

`ifdef PKT_DROP_EN
    typedef enum logic [2:0] {ST_SOP = 3'b001, ST_BODY = 3'b010, ST_DROP = 3'b100} state_t;
`else
    typedef enum logic [2:0] {ST_SOP = 3'b001, ST_BODY = 3'b010} state_t;
`endif

    state_t           state;
    logic [LEN_W-1:0] len_acc;
    logic [LEN_W:0]   strb_cnt;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] len_sat;
    logic             tready_raw;
    logic             tready;
    logic             accept;
    logic             drop_now;

    // Packets being discarded: the whole DROP state plus the SOP beat that triggers it
`ifdef PKT_DROP_EN
    assign drop_now = (state == ST_DROP) |
                      ((state == ST_SOP) & bus.s_axis_tvalid & bus.fifo_almost_full);
`else
    assign drop_now = 1'b0;
`endif

    // Byte count of the current beat, then running length saturated at all-ones
    always_comb begin
        strb_cnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb_cnt = strb_cnt + {{LEN_W{1'b0}}, bus.s_axis_tstrb[i]};
        end
        len_sum = {1'b0, len_acc} + strb_cnt;
        len_sat = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    // Ready from state and FIFO flags only; almost-full gates only the start of a packet
    always_comb begin
        tready_raw = 1'b0;
        case (state)
            ST_SOP:  tready_raw = ~bus.fifo_almost_full & ~bus.fifo_full &
                                  ~(bus.s_axis_tlast & bus.user_full);
            ST_BODY: tready_raw = ~bus.fifo_full & ~(bus.s_axis_tlast & bus.user_full);
            default: tready_raw = 1'b0;
        endcase
        if (drop_now) begin
            tready_raw = 1'b1;
        end
    end

    assign tready            = aresetn & tready_raw;
    assign accept            = bus.s_axis_tvalid & tready;
    assign bus.s_axis_tready = tready;

    assign bus.fifo_wr_en    = accept & ~drop_now;
    assign bus.fifo_din_data = bus.s_axis_tdata;
    assign bus.fifo_din_strb = bus.s_axis_tstrb;
    assign bus.fifo_din_last = bus.s_axis_tlast;

    assign bus.user_wr_en    = accept & bus.s_axis_tlast & ~drop_now;
    assign bus.user_len      = len_sat;
    assign bus.user_spt      = C_SRC_PORT;

    // Packet FSM, running length and packet counters advance on each accepted beat
    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_SOP;
            len_acc <= '0;
            pkt_cnt <= '0;
`ifdef PKT_DROP_EN
            drop_cnt <= '0;
`endif
        end else if (accept) begin
            if (bus.s_axis_tlast) begin
                state   <= ST_SOP;
                len_acc <= '0;
                if (!drop_now) begin
                    pkt_cnt <= pkt_cnt + 32'd1;
                end
`ifdef PKT_DROP_EN
                else begin
                    drop_cnt <= drop_cnt + 32'd1;
                end
`endif
            end else begin
                len_acc <= len_sat;
`ifdef PKT_DROP_EN
                state   <= drop_now ? ST_DROP : ST_BODY;
`else
                state   <= ST_BODY;
`endif
            end
        end
    end

`ifndef PKT_DROP_EN
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_in_writer.sv
// tb/tb_pkt_in_writer.sv - table-driven bench for pkt_in_writer (default or PKT_DROP_EN build)
module tb_pkt_in_writer;
    localparam int DW  = 64;
    localparam int LW  = 5;
    localparam int SW  = 8;
    localparam logic [SW-1:0] SRC = 8'h05;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    pkt_in_writer_if #(.DATA_W(DW), .LEN_W(LW), .SPT_W(SW)) bus ();

    pkt_in_writer #(
        .C_AXIS_DATA_WIDTH    (DW),
        .C_AXIS_LEN_DATA_WIDTH(LW),
        .C_AXIS_SPT_DATA_WIDTH(SW),
        .C_SRC_PORT           (SRC)
    ) dut (
        .asclk   (clk),
        .aresetn (rst_n),
        .bus     (bus),
        .pkt_cnt (pkt_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  strb;
        logic        ff;
        logic        af;
        logic        uf;
        logic        rdy;
        logic        wr;
        logic        uwr;
        logic [LW-1:0] len;
        logic [31:0] pkt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic l, input logic [7:0] strb,
                                input logic ff, input logic af, input logic uf,
                                input logic rdy, input logic wr, input logic uwr,
                                input logic [LW-1:0] len, input logic [31:0] pkt);
        vec_t r;
        r.v = v; r.l = l; r.strb = strb; r.ff = ff; r.af = af; r.uf = uf;
        r.rdy = rdy; r.wr = wr; r.uwr = uwr; r.len = len; r.pkt = pkt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] strb,
                         input logic ff, input logic af, input logic uf, input logic [63:0] d);
        bus.s_axis_tvalid    = v;
        bus.s_axis_tlast     = l;
        bus.s_axis_tstrb     = strb;
        bus.s_axis_tdata     = d;
        bus.fifo_full        = ff;
        bus.fifo_almost_full = af;
        bus.user_full        = uf;
    endtask

    initial begin
        logic [63:0] d;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0);

        // Reset state: outputs forced low even with a valid beat offered
        repeat (2) @(negedge clk);
        #2;
        chk("reset tready", {63'b0, bus.s_axis_tready}, 64'd0);
        chk("reset fifo_wr_en", {63'b0, bus.fifo_wr_en}, 64'd0);
        chk("reset user_wr_en", {63'b0, bus.user_wr_en}, 64'd0);
        chk("reset pkt_cnt", {32'b0, pkt_cnt}, 64'd0);
        chk("reset drop_cnt", {32'b0, drop_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0);

        //             v     l     strb   ff    af    uf    rdy   wr    uwr   len    pkt
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  0));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  0));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd20, 0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  1));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  2));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 2));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 2));
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd17, 2));
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd17, 2));
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd17, 2));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8,  3));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 3));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd24, 3));
        vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 3));
        vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  4));
        vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  4));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5));

        foreach (vecs[i]) begin
            @(negedge clk);
            d = 64'hA5A5_0000_0000_0000 | 64'(i);
            drive(vecs[i].v, vecs[i].l, vecs[i].strb, vecs[i].ff, vecs[i].af, vecs[i].uf, d);
            #2;
            chk($sformatf("v%0d tready", i), {63'b0, bus.s_axis_tready}, {63'b0, vecs[i].rdy});
            chk($sformatf("v%0d fifo_wr_en", i), {63'b0, bus.fifo_wr_en}, {63'b0, vecs[i].wr});
            chk($sformatf("v%0d user_wr_en", i), {63'b0, bus.user_wr_en}, {63'b0, vecs[i].uwr});
            chk($sformatf("v%0d user_len", i), {59'b0, bus.user_len}, {59'b0, vecs[i].len});
            chk($sformatf("v%0d pkt_cnt", i), {32'b0, pkt_cnt}, {32'b0, vecs[i].pkt});
            chk($sformatf("v%0d din_data", i), bus.fifo_din_data, d);
            chk($sformatf("v%0d din_strb", i), {56'b0, bus.fifo_din_strb}, {56'b0, vecs[i].strb});
            chk($sformatf("v%0d din_last", i), {63'b0, bus.fifo_din_last}, {63'b0, vecs[i].l});
            chk($sformatf("v%0d user_spt", i), {56'b0, bus.user_spt}, {56'b0, SRC});
        end

`ifdef PKT_DROP_EN
        // Almost-full at SOP: whole 4-beat packet consumed with no FIFO writes
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, (k == 3), 8'hFF, 1'b0, 1'b1, 1'b0, 64'h0);
            #2;
            chk($sformatf("drop%0d tready", k), {63'b0, bus.s_axis_tready}, 64'd1);
            chk($sformatf("drop%0d fifo_wr_en", k), {63'b0, bus.fifo_wr_en}, 64'd0);
            chk($sformatf("drop%0d user_wr_en", k), {63'b0, bus.user_wr_en}, 64'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("drop drop_cnt", {32'b0, drop_cnt}, 64'd1);
        chk("drop pkt_cnt", {32'b0, pkt_cnt}, 64'd5);
`else
        // Almost-full at SOP stalls; once the packet starts, almost-full is ignored
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 64'h0);
            #2;
            chk($sformatf("af%0d tready", k), {63'b0, bus.s_axis_tready}, 64'd0);
            chk($sformatf("af%0d fifo_wr_en", k), {63'b0, bus.fifo_wr_en}, 64'd0);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("af release tready", {63'b0, bus.s_axis_tready}, 64'd1);
        chk("af release fifo_wr_en", {63'b0, bus.fifo_wr_en}, 64'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 64'h0);
        #2;
        chk("af body tready", {63'b0, bus.s_axis_tready}, 64'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("af last user_wr_en", {63'b0, bus.user_wr_en}, 64'd1);
        chk("af last user_len", {59'b0, bus.user_len}, 64'd20);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("af pkt_cnt", {32'b0, pkt_cnt}, 64'd6);
        chk("af drop_cnt", {32'b0, drop_cnt}, 64'd0);
`endif

        // Reset pulsed mid-packet: outputs low during reset, next packet length counted from 0
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("rst pre fifo_wr_en", {63'b0, bus.fifo_wr_en}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst mid tready", {63'b0, bus.s_axis_tready}, 64'd0);
        chk("rst mid fifo_wr_en", {63'b0, bus.fifo_wr_en}, 64'd0);
        chk("rst mid pkt_cnt", {32'b0, pkt_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("rst post user_wr_en", {63'b0, bus.user_wr_en}, 64'd1);
        chk("rst post user_len", {59'b0, bus.user_len}, 64'd4);
        chk("rst post pkt_cnt", {32'b0, pkt_cnt}, 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0);
        #2;
        chk("rst final pkt_cnt", {32'b0, pkt_cnt}, 64'd1);
        chk("rst final drop_cnt", {32'b0, drop_cnt}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
